// File: rtl/lut_cfg_loader.sv
// lut_cfg_loader: assembles serial bitstream words and pulses one-hot slice enables
module lut_cfg_loader #(
    parameter int INPUTS      = 4,
    parameter int MEM_SIZE    = 2**INPUTS,
    parameter int CFG_WIDTH   = 2*MEM_SIZE+1,
    parameter int NUM_TARGETS = 4
) (
    input  logic                   cclk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   bs_valid,
    input  logic                   bs_data,
    output logic                   bs_ready,
    output logic [CFG_WIDTH-1:0]   config_out,
    output logic [NUM_TARGETS-1:0] cen,
    output logic                   busy,
    output logic                   done,
    output logic                   aborted
);
    localparam int CW = $clog2(CFG_WIDTH);
    localparam int TW = NUM_TARGETS > 1 ? $clog2(NUM_TARGETS) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(CFG_WIDTH-1);
    localparam logic [TW-1:0] LAST_TGT = TW'(NUM_TARGETS-1);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0]           state;
    logic [CFG_WIDTH-2:0] sr;
    logic [CW-1:0]        bit_cnt;
    logic [TW-1:0]        tgt;
    logic [CFG_WIDTH-1:0] nxt;

    // Outputs decode from state so an async reset clears them immediately
    always_comb begin
        nxt      = {sr, bs_data};
        bs_ready = (state == SHIFT) && !abort;
        busy     = state != IDLE;
        done     = state == DONE;
        cen      = (state == COMMIT) ? NUM_TARGETS'(1) << tgt : '0;
    end

    // Sequencer: shift bits in, latch the finished word, step through targets
    always_ff @(posedge cclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sr         <= '0;
            bit_cnt    <= '0;
            tgt        <= '0;
            config_out <= '0;
            aborted    <= 1'b0;
        end else begin
            aborted <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state   <= SHIFT;
                    bit_cnt <= '0;
                    tgt     <= '0;
                end
                SHIFT: if (abort) begin
                    state   <= IDLE;
                    aborted <= 1'b1;
                end else if (bs_valid) begin
                    sr      <= nxt[CFG_WIDTH-2:0];
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        config_out <= nxt;
                        state      <= COMMIT;
                    end
                end
                COMMIT: if (abort) begin
                    state   <= IDLE;
                    aborted <= 1'b1;
                end else if (tgt == LAST_TGT) begin
                    state <= DONE;
                end else begin
                    tgt     <= tgt + 1'b1;
                    bit_cnt <= '0;
                    state   <= SHIFT;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
